// File: rtl/regfile_wb_tracer.sv
// regfile_wb_tracer: captures register-file writebacks to one watched register into a
// show-ahead FIFO streamed out on valid/ready, with sticky overflow and a drop counter.
module regfile_wb_tracer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [ADDR_W-1:0]        watch_addr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEQ_W-1:0]         out_seq,
  input  logic                     ovf_clr,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0]       r_wr, r_rd;
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [SEQ_W-1:0]  r_mem_seq  [DEPTH];
  logic [SEQ_W-1:0]  r_seq;
  logic              r_ovf;
  logic [7:0]        r_cnt;
  logic w_empty, w_full, w_hit, w_pop, w_push, w_drop;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
  assign w_hit   = wb_en && (wb_addr == watch_addr) && (wb_addr != '0);
  assign w_pop   = !w_empty && out_ready;
  // a pop frees the slot the full-FIFO push lands in, so both may happen together
  assign w_push  = w_hit && (!w_full || w_pop);
  assign w_drop  = w_hit && w_full && !w_pop;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem_data[r_rd[PW-1:0]];
  assign out_seq   = w_empty ? '0 : r_mem_seq[r_rd[PW-1:0]];
  assign overflow  = r_ovf;
  assign drop_cnt  = r_cnt;
  assign level     = r_wr - r_rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_seq <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + {{PW{1'b0}}, w_push};
      r_rd  <= r_rd + {{PW{1'b0}}, w_pop};
      r_seq <= r_seq + {{(SEQ_W-1){1'b0}}, w_hit};
      r_ovf <= w_drop ? 1'b1 : ovf_clr ? 1'b0 : r_ovf;
      r_cnt <= w_drop ? (ovf_clr ? 8'd1 : r_cnt + {7'd0, r_cnt != 8'hff})
             : ovf_clr ? 8'd0 : r_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr[PW-1:0]] <= wb_data;
      r_mem_seq[r_wr[PW-1:0]]  <= r_seq;
    end
  end
endmodule

// File: tb/tb_regfile_wb_tracer.sv
// tb_regfile_wb_tracer: directed and random stimulus checked against a queue-based model.
module tb_regfile_wb_tracer;
  localparam int DEPTH = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  watch_addr = 5'd9;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_seq;
  logic        ovf_clr = 1'b0;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [3:0]  level;

  regfile_wb_tracer dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .watch_addr(watch_addr), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_seq(out_seq), .ovf_clr(ovf_clr), .overflow(overflow),
    .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [7:0] s; } ent_t;
  ent_t q[$];
  int   m_seq = 0;
  bit   m_ovf = 0;
  int   m_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_data", 64'(out_data), q.size() != 0 ? 64'(q[0].d) : 64'd0);
    chk("out_seq", 64'(out_seq), q.size() != 0 ? 64'(q[0].s) : 64'd0);
    chk("level", 64'(level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
  endtask

  task automatic step(input bit en, input logic [4:0] a, input logic [31:0] d,
                      input bit rdy, input bit clr);
    bit pop, hit;
    wb_en = en; wb_addr = a; wb_data = d; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    pop = q.size() != 0 && rdy;
    hit = en && a == watch_addr && a != 0;
    if (pop) void'(q.pop_front());
    if (hit) begin
      if (q.size() < DEPTH) q.push_back('{d, 8'(m_seq)});
      else begin
        m_ovf = 1;
        m_cnt = clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
      end
      m_seq = (m_seq + 1) % 256;
    end
    if (clr && !(hit && q.size() == DEPTH && !pop && m_cnt == 1 && m_ovf)) begin
      if (!(hit && !pop && q.size() == DEPTH && m_ovf && m_cnt == 1)) begin
        m_ovf = 0; m_cnt = 0;
      end
    end
    #1 check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    q.delete(); m_seq = 0; m_ovf = 0; m_cnt = 0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int fib[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    #2;
    check_all();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    // test 1: Fibonacci stream on r9
    for (int i = 0; i < 10; i++) begin
      step(1, 5'd9, 32'(fib[i]), 1, 0);
      chk("t1_data", 64'(out_data), 64'(fib[i]));
      chk("t1_seq", 64'(out_seq), 64'(i));
    end
    step(0, 0, 0, 1, 0);
    chk("t1_ovf", 64'(overflow), 64'd0);
    // test 2: non-watched and $zero writes
    step(1, 5'd8, 32'h55, 1, 0);
    step(1, 5'd0, 32'd7, 1, 0);
    watch_addr = 5'd0;
    step(1, 5'd0, 32'd3, 1, 0);
    chk("t2_valid", 64'(out_valid), 64'd0);
    chk("t2_level", 64'(level), 64'd0);
    watch_addr = 5'd9;
    // test 3: overflow with 10 hits into 8 slots
    async_reset();
    for (int i = 1; i <= 10; i++) step(1, 5'd9, 32'(i), 0, 0);
    chk("t3_level", 64'(level), 64'd8);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_drop", 64'(drop_cnt), 64'd2);
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain_data", 64'(out_data), 64'(i));
      chk("t3_drain_seq", 64'(out_seq), 64'(i - 1));
      step(0, 0, 0, 1, 0);
    end
    step(1, 5'd9, 32'h77, 0, 0);
    chk("t3_next_seq", 64'(out_seq), 64'd10);
    step(0, 0, 0, 1, 0);
    // test 5a: clear
    step(0, 0, 0, 0, 1);
    chk("t5_ovf_clr", 64'(overflow), 64'd0);
    chk("t5_cnt_clr", 64'(drop_cnt), 64'd0);
    // test 4: full with simultaneous pop
    for (int i = 0; i < 8; i++) step(1, 5'd9, 32'h100 + 32'(i), 0, 0);
    step(1, 5'd9, 32'hABCD, 1, 0);
    chk("t4_level", 64'(level), 64'd8);
    chk("t4_nodrop", 64'(drop_cnt), 64'd0);
    // test 5b: clear coincident with a drop
    step(1, 5'd9, 32'hDEAD, 0, 1);
    chk("t5_set_ovf", 64'(overflow), 64'd1);
    chk("t5_set_cnt", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
    chk("t4_last", 64'(out_data), 64'hABCD);
    step(0, 0, 0, 1, 0);
    // random phase
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      int r = $urandom_range(0, 3);
      a = r == 0 ? 5'd9 : r == 1 ? 5'd0 : r == 2 ? 5'd8 : 5'($urandom);
      if ($urandom_range(0, 49) == 0) watch_addr = $urandom_range(0, 1) ? 5'd8 : 5'd9;
      step($urandom_range(0, 3) != 0, a, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0);
    end
    // test 6: async reset with 5 queued
    watch_addr = 5'd9;
    step(0, 0, 0, 1, 0);
    while (q.size() != 0) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 5'd9, 32'h600 + 32'(i), 0, 0);
    chk("t6_pre_level", 64'(level), 64'd5);
    async_reset();
    step(1, 5'd9, 32'h1234, 0, 0);
    chk("t6_seq", 64'(out_seq), 64'd0);
    chk("t6_data", 64'(out_data), 64'h1234);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
